cyclic_bank_reqmux: RTL and testbench
=====================================

# cyclic_bank_reqmux

- Upstream request mux for the cyclic-memory cache banks.
- Accepts byte-addressed load/store requests from `PORTS` user ports and steers each request to one of `BANKS` cyclic cache banks using word interleaving.
- Arbitrates round-robin per bank and drives each bank's `cyclic_mux_*` request bus.
- Routes each bank's read data back to the port that issued the read, using a per-bank port-ID tag FIFO.

## Interface
Parameters:
- `PORTS`, 4: number of user ports (≥2).
- `BANKS`, 4: number of cyclic banks (power of 2).
- `AW`, 32: user byte-address width.
- `DW`, 32: data width.
- `BANK_AW`, `AW-$clog2(BANKS)`: per-bank byte-address width.
- `RD_OSTD`, 4: per-bank tag FIFO depth (max outstanding reads per bank).

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `usr_re` / `usr_we` in 1 ×PORTS: read / write request.
- `usr_len` in 2 ×PORTS: 0=byte, 1=half, 3=word.
- `usr_adr` in AW ×PORTS: byte address.
- `usr_din` in DW ×PORTS: write data.
- `usr_ready` out 1 ×PORTS: request accepted this cycle.
- `usr_dout` out DW ×PORTS: read data.
- `usr_dout_vld` out 1 ×PORTS: read data valid.
- `cyclic_mux_ready` in 1 ×BANKS: bank can accept.
- `cyclic_mux_re` / `cyclic_mux_we` out 1 ×BANKS: bank request.
- `cyclic_mux_len` out 2 ×BANKS: forwarded length.
- `cyclic_mux_bankAdr` out BANK_AW ×BANKS: bank byte address.
- `cyclic_mux_din` out DW ×BANKS: write data.
- `cyclic_mux_dout` in DW ×BANKS: bank read data.
- `cyclic_mux_dout_vld` in 1 ×BANKS: bank read data valid (in-order per bank).
- `err_orphan_rd` out 1: sticky; bank returned data with an empty tag FIFO.

## Operation
- **Bank select:** `bank = usr_adr[2 +: log2(BANKS)]`.
- **Bank address:** `bankAdr = {usr_adr[AW-1:2+log2(BANKS)], usr_adr[1:0]}`.
- **Simultaneous re and we on one port:** illegal; `we` wins.
- **Request eligibility:** a port requests its bank when (`re|we`) and it has no pending read.
- **Per-bank arbiter:** round-robin over eligible ports. Pointer `rr[b]` resets to 0. After an accepted grant to port p, `rr[b] = (p+1) % PORTS`.
- **Accept condition for bank b:** a grant exists && `cyclic_mux_ready[b]` && (grant is write || FIFO not full || FIFO popping this cycle).
- **Accept actions:**
  - `usr_ready[p]=1`.
  - Bank bus driven with port p's fields and `re`/`we` high.
  - On read: push p into `tagq[b]` and set `pend[p]`.
- **No accept:** `cyclic_mux_re/we[b]=0`; other bank outputs hold don't-care (drive granted port's fields).
- **Return path:** `cyclic_mux_dout_vld[b]` pops `tagq[b]` head h, then `usr_dout[h]=cyclic_mux_dout[b]`, `usr_dout_vld[h]=1`, and `pend[h]` clears at the clock edge.
- **Collision:** a port can have only one pending read, so two banks never return to the same port in one cycle.
- **Empty-FIFO return:** data is dropped and `err_orphan_rd` is set; it is cleared only by reset.
- **Writes:** posted; no tag, no pending.
- **Reset values:** all outputs 0; `rr`=0; all `tagq` empty; `pend`=0.
- **Reset mid-operation:** all of the above cleared. Responses from banks that arrive after reset release are orphaned and flagged.

## Timing
- **Grant path:** combinational, request to `usr_ready` / bank request in the same cycle. No request-side register stage.
- **Read latency:** bank latency + 0 cycles (+1 with the configuration macro).
- **Pending clear:** `pend[p]` drops at the edge of the `dout_vld` cycle. The next read from that port can be accepted at the earliest in the following cycle.
- **Tag FIFO:** simultaneous push/pop at full is allowed and the count is unchanged. Count width is `$clog2(RD_OSTD+1)`.
- **Round-robin pointer:** advances only on accept; a stalled bank (`ready=0`) leaves it unchanged.

## Configuration
- **`CYCLIC_REQMUX_RDATA_REG_EN` defined:** `usr_dout` / `usr_dout_vld` are registered, giving +1 cycle return latency. `pend[p]` clears on the registered valid.
- **Not defined:** the return path is combinational from `cyclic_mux_dout*`.

## Test plan
- **Address steering:** port 0 writes `0x0000_0014` word `0xDEADBEEF`, `BANKS`=4 → bank 1 sees `we=1`, `bankAdr=0x04`, `din=0xDEADBEEF`, same cycle as `usr_ready[0]=1`.
- **Round-robin fairness:** ports 0–3 all read bank 2 continuously with `ready=1` → grants in order 0,1,2,3. Read data returns to ports in the same order. Each port is re-granted only after its `dout_vld`.
- **FIFO full backpressure:** `RD_OSTD`=4 and bank 0 withholds `dout_vld` with 4 reads outstanding → 5th read is not accepted. A write to bank 0 is still accepted. Accepted same cycle as the first pop.
- **Cross-bank return:** port 1 reads bank 3 and port 2 reads bank 0; bank 0 returns first → `usr_dout_vld[2]` precedes `usr_dout_vld[1]` with the correct data.
- **Reset mid-flight:** `rstn` low for 1 cycle with 2 reads outstanding, then bank returns `dout_vld` → no `usr_dout_vld`, `err_orphan_rd=1`, and `rr`/`pend` are 0.
- **Macro on vs off:** with `CYCLIC_REQMUX_RDATA_REG_EN`, the same read stream returns identical data exactly 1 cycle later than without it.

Source files
------------

// File: rtl/cyclic_bank_reqmux.sv
// Request mux: steers byte-addressed user loads/stores to word-interleaved cyclic
// banks and routes per-bank read data back to the issuing port via a port-ID tag FIFO.
// Latency: request path combinational; read return = bank latency (+1 cycle when
// CYCLIC_REQMUX_RDATA_REG_EN is defined). Backpressure: usr_ready low while the
// bank is not ready or its tag FIFO is full without popping.
module cyclic_bank_reqmux #(
  parameter int PORTS   = 4,
  parameter int BANKS   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BANK_AW = AW - $clog2(BANKS),
  parameter int RD_OSTD = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [PORTS-1:0]       usr_re,
  input  logic [PORTS-1:0]       usr_we,
  input  logic [2*PORTS-1:0]     usr_len,
  input  logic [AW*PORTS-1:0]    usr_adr,
  input  logic [DW*PORTS-1:0]    usr_din,
  output logic [PORTS-1:0]       usr_ready,
  output logic [DW*PORTS-1:0]    usr_dout,
  output logic [PORTS-1:0]       usr_dout_vld,
  input  logic [BANKS-1:0]       cyclic_mux_ready,
  output logic [BANKS-1:0]       cyclic_mux_re,
  output logic [BANKS-1:0]       cyclic_mux_we,
  output logic [2*BANKS-1:0]     cyclic_mux_len,
  output logic [BANK_AW*BANKS-1:0] cyclic_mux_bankAdr,
  output logic [DW*BANKS-1:0]    cyclic_mux_din,
  input  logic [DW*BANKS-1:0]    cyclic_mux_dout,
  input  logic [BANKS-1:0]       cyclic_mux_dout_vld,
  output logic                   err_orphan_rd
);

  // BANKS is expected to be a power of two and at least 2.
  localparam int PW = $clog2(PORTS);
  localparam int BL = $clog2(BANKS);
  localparam int QW = (RD_OSTD > 1) ? $clog2(RD_OSTD) : 1;
  localparam int CW = $clog2(RD_OSTD + 1);
  localparam int HW = AW - 2 - BL;

  logic [PORTS-1:0] pend;
  logic [PW-1:0]    rr    [BANKS];
  logic [PW-1:0]    tagq  [BANKS][RD_OSTD];
  logic [QW-1:0]    wptr  [BANKS];
  logic [QW-1:0]    rptr  [BANKS];
  logic [CW-1:0]    cnt   [BANKS];

  logic [PORTS-1:0] elig;
  logic [BL-1:0]    psel  [PORTS];
  logic [BANKS-1:0] gvld;
  logic [PW-1:0]    gidx  [BANKS];
  logic [BANKS-1:0] gwr;
  logic [BANKS-1:0] acc;
  logic [BANKS-1:0] push;
  logic [BANKS-1:0] pop;
  logic [BANKS-1:0] orphan;
  logic [PORTS-1:0] rd_set;
  logic [PORTS-1:0] rd_clr;
  logic [PORTS-1:0] ret_vld;
  logic [DW*PORTS-1:0] ret_dat;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] v);
    return (v == QW'(RD_OSTD - 1)) ? '0 : v + 1'b1;
  endfunction

  // A port competes for its target bank when it asks and has no read in flight.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      psel[p] = usr_adr[p*AW + 2 +: BL];
      elig[p] = rstn & (usr_re[p] | usr_we[p]) & ~pend[p];
    end
  end

  // Round-robin search per bank, starting at that bank's pointer.
  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < BANKS; b++) begin
      gvld[b] = 1'b0;
      gidx[b] = '0;
      for (int k = 0; k < PORTS; k++) begin
        idx = (int'(rr[b]) + k) % PORTS;
        if (!gvld[b] && elig[idx] && (psel[idx] == BL'(b))) begin
          gvld[b] = 1'b1;
          gidx[b] = PW'(idx);
        end
      end
    end
  end

  // Accept decision and bank bus drive; a pop in the same cycle frees a full FIFO slot.
  always_comb begin
    usr_ready          = '0;
    rd_set             = '0;
    cyclic_mux_re      = '0;
    cyclic_mux_we      = '0;
    cyclic_mux_len     = '0;
    cyclic_mux_bankAdr = '0;
    cyclic_mux_din     = '0;
    for (int b = 0; b < BANKS; b++) begin
      // we has priority over re when both are raised.
      gwr[b]    = usr_we[gidx[b]];
      pop[b]    = rstn & cyclic_mux_dout_vld[b] & (cnt[b] != '0);
      orphan[b] = rstn & cyclic_mux_dout_vld[b] & (cnt[b] == '0);
      acc[b]    = gvld[b] & cyclic_mux_ready[b] &
                  (gwr[b] | (cnt[b] != CW'(RD_OSTD)) | pop[b]);
      push[b]   = acc[b] & ~gwr[b];
      cyclic_mux_re[b] = acc[b] & ~gwr[b];
      cyclic_mux_we[b] = acc[b] & gwr[b];
      if (rstn) begin
        cyclic_mux_len[b*2 +: 2] = usr_len[int'(gidx[b])*2 +: 2];
        cyclic_mux_bankAdr[b*BANK_AW +: BANK_AW] =
          {usr_adr[int'(gidx[b])*AW + 2 + BL +: HW], usr_adr[int'(gidx[b])*AW +: 2]};
        cyclic_mux_din[b*DW +: DW] = usr_din[int'(gidx[b])*DW +: DW];
      end
      if (acc[b]) begin
        usr_ready[gidx[b]] = 1'b1;
      end
      if (push[b]) begin
        rd_set[gidx[b]] = 1'b1;
      end
    end
  end

  // Return steering: each bank's FIFO head names the port that owns the data.
  always_comb begin
    ret_vld = '0;
    ret_dat = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (pop[b]) begin
        ret_vld[tagq[b][rptr[b]]] = 1'b1;
        ret_dat[int'(tagq[b][rptr[b]])*DW +: DW] = cyclic_mux_dout[b*DW +: DW];
      end
    end
  end

`ifdef CYCLIC_REQMUX_RDATA_REG_EN
  // Registered return stage; pending clears when the registered valid is seen.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      usr_dout     <= '0;
      usr_dout_vld <= '0;
    end else begin
      usr_dout     <= ret_dat;
      usr_dout_vld <= ret_vld;
    end
  end
  assign rd_clr = usr_dout_vld;
`else
  assign usr_dout     = ret_dat;
  assign usr_dout_vld = ret_vld;
  assign rd_clr       = ret_vld;
`endif

  // Tag FIFO storage; validity is tracked by pointers and count, so no reset needed.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (push[b]) begin
        tagq[b][wptr[b]] <= gidx[b];
      end
    end
  end

  // Control state: pending flags, arbiter pointers, FIFO pointers/counts, orphan flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend          <= '0;
      err_orphan_rd <= 1'b0;
      for (int b = 0; b < BANKS; b++) begin
        rr[b]   <= '0;
        wptr[b] <= '0;
        rptr[b] <= '0;
        cnt[b]  <= '0;
      end
    end else begin
      pend          <= (pend & ~rd_clr) | rd_set;
      err_orphan_rd <= err_orphan_rd | (|orphan);
      for (int b = 0; b < BANKS; b++) begin
        if (acc[b]) begin
          rr[b] <= (gidx[b] == PW'(PORTS - 1)) ? '0 : gidx[b] + 1'b1;
        end
        if (push[b]) begin
          wptr[b] <= qinc(wptr[b]);
        end
        if (pop[b]) begin
          rptr[b] <= qinc(rptr[b]);
        end
        case ({push[b], pop[b]})
          2'b10:   cnt[b] <= cnt[b] + 1'b1;
          2'b01:   cnt[b] <= cnt[b] - 1'b1;
          default: cnt[b] <= cnt[b];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cyclic_bank_reqmux.sv
// Directed bench for cyclic_bank_reqmux: steering, round-robin, tag FIFO limits,
// cross-bank return, reset mid-flight and return latency.
// Five ports are used so that four reads can be outstanding on one bank while a fifth port still asks.
module tb_cyclic_bank_reqmux;

  localparam int P   = 5;
  localparam int B   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BAW = 30;
  localparam int OST = 4;
`ifdef CYCLIC_REQMUX_RDATA_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             rstn;
  logic [P-1:0]     usr_re;
  logic [P-1:0]     usr_we;
  logic [2*P-1:0]   usr_len;
  logic [AW*P-1:0]  usr_adr;
  logic [DW*P-1:0]  usr_din;
  logic [P-1:0]     usr_ready;
  logic [DW*P-1:0]  usr_dout;
  logic [P-1:0]     usr_dout_vld;
  logic [B-1:0]     cyclic_mux_ready;
  logic [B-1:0]     cyclic_mux_re;
  logic [B-1:0]     cyclic_mux_we;
  logic [2*B-1:0]   cyclic_mux_len;
  logic [BAW*B-1:0] cyclic_mux_bankAdr;
  logic [DW*B-1:0]  cyclic_mux_din;
  logic [DW*B-1:0]  cyclic_mux_dout;
  logic [B-1:0]     cyclic_mux_dout_vld;
  logic             err_orphan_rd;

  int n_checks;
  int n_fail;

  cyclic_bank_reqmux #(
    .PORTS(P), .BANKS(B), .AW(AW), .DW(DW), .BANK_AW(BAW), .RD_OSTD(OST)
  ) dut (
    .clk(clk), .rstn(rstn),
    .usr_re(usr_re), .usr_we(usr_we), .usr_len(usr_len), .usr_adr(usr_adr),
    .usr_din(usr_din), .usr_ready(usr_ready), .usr_dout(usr_dout),
    .usr_dout_vld(usr_dout_vld),
    .cyclic_mux_ready(cyclic_mux_ready), .cyclic_mux_re(cyclic_mux_re),
    .cyclic_mux_we(cyclic_mux_we), .cyclic_mux_len(cyclic_mux_len),
    .cyclic_mux_bankAdr(cyclic_mux_bankAdr), .cyclic_mux_din(cyclic_mux_din),
    .cyclic_mux_dout(cyclic_mux_dout), .cyclic_mux_dout_vld(cyclic_mux_dout_vld),
    .err_orphan_rd(err_orphan_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_req();
    usr_re = '0;
    usr_we = '0;
  endtask

  task automatic set_req(input int p, input logic re, input logic we, input logic [1:0] len,
                         input logic [31:0] adr, input logic [31:0] din);
    usr_re[p]             = re;
    usr_we[p]             = we;
    usr_len[p*2 +: 2]     = len;
    usr_adr[p*AW +: AW]   = adr;
    usr_din[p*DW +: DW]   = din;
  endtask

  task automatic bank_ret(input int b, input logic [31:0] d);
    cyclic_mux_dout_vld[b]      = 1'b1;
    cyclic_mux_dout[b*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyclic_mux_dout_vld = '0;
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0);
    bank_ret(0, 32'h1234);
    #2;
    n_checks++;
    if (usr_ready !== 5'b0) begin n_fail++; $display("FAIL reset_ready: got %b want %b", usr_ready, 5'b0); end
    n_checks++;
    if (cyclic_mux_re !== 4'b0 || cyclic_mux_we !== 4'b0) begin
      n_fail++; $display("FAIL reset_bank_req: got re=%b we=%b want 0", cyclic_mux_re, cyclic_mux_we);
    end
    n_checks++;
    if (usr_dout_vld !== 5'b0) begin n_fail++; $display("FAIL reset_dout_vld: got %b want 0", usr_dout_vld); end
    next_cycle();
    next_cycle();
    n_checks++;
    if (err_orphan_rd !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_orphan_rd); end
    clr_req();
    rstn = 1'b1;
  endtask

  task automatic test_steering();
    set_req(0, 1'b0, 1'b1, 2'd3, 32'h0000_0014, 32'hDEAD_BEEF);
    #2;
    n_checks++;
    if (usr_ready !== 5'b00001) begin n_fail++; $display("FAIL steer_ready: got %b want 00001", usr_ready); end
    n_checks++;
    if (cyclic_mux_we !== 4'b0010 || cyclic_mux_re !== 4'b0000) begin
      n_fail++; $display("FAIL steer_we: got we=%b re=%b want we=0010 re=0000", cyclic_mux_we, cyclic_mux_re);
    end
    n_checks++;
    if (cyclic_mux_bankAdr[1*BAW +: BAW] !== 30'h4) begin
      n_fail++; $display("FAIL steer_adr: got %h want 4", cyclic_mux_bankAdr[1*BAW +: BAW]);
    end
    n_checks++;
    if (cyclic_mux_din[1*DW +: DW] !== 32'hDEAD_BEEF || cyclic_mux_len[2 +: 2] !== 2'd3) begin
      n_fail++; $display("FAIL steer_din: got din=%h len=%0d want deadbeef len=3",
                         cyclic_mux_din[1*DW +: DW], cyclic_mux_len[2 +: 2]);
    end
    next_cycle();
    clr_req();
  endtask

  task automatic test_rdata_latency();
    set_req(0, 1'b1, 1'b0, 2'd3, 32'h0000_0004, 32'h0);
    #2;
    n_checks++;
    if (usr_ready !== 5'b00001 || cyclic_mux_re !== 4'b0010) begin
      n_fail++; $display("FAIL lat_accept: got ready=%b re=%b want 00001/0010", usr_ready, cyclic_mux_re);
    end
    next_cycle();
    clr_req();
    bank_ret(1, 32'h5A5A_0001);
    for (int k = 0; k < 2; k++) begin
      #2;
      n_checks++;
      if (k == LAT) begin
        if (usr_dout_vld !== 5'b00001 || usr_dout[0 +: DW] !== 32'h5A5A_0001) begin
          n_fail++; $display("FAIL lat_return k=%0d: got vld=%b dout=%h want 00001/5a5a0001",
                             k, usr_dout_vld, usr_dout[0 +: DW]);
        end
      end else begin
        if (usr_dout_vld !== 5'b0) begin
          n_fail++; $display("FAIL lat_idle k=%0d: got vld=%b want 0", k, usr_dout_vld);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < 4; p++) set_req(p, 1'b1, 1'b0, 2'd3, 32'h08 + 32'h10 * p, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #2;
      n_checks++;
      if (usr_ready !== 5'(1 << c) || cyclic_mux_re !== 4'b0100 ||
          cyclic_mux_bankAdr[2*BAW +: BAW] !== 30'(4 * c)) begin
        n_fail++; $display("FAIL rr_grant c=%0d: got ready=%b re=%b adr=%h want ready=%b re=0100 adr=%h",
                           c, usr_ready, cyclic_mux_re, cyclic_mux_bankAdr[2*BAW +: BAW], 5'(1 << c), 4 * c);
      end
      next_cycle();
    end
    bank_ret(2, 32'h104);
    #2;
    n_checks++;
    if (usr_ready !== 5'b0 || usr_dout_vld !== 5'b00001 || usr_dout[0 +: DW] !== 32'h104) begin
      n_fail++; $display("FAIL rr_all_pending: got ready=%b vld=%b dout=%h want 0/00001/104",
                         usr_ready, usr_dout_vld, usr_dout[0 +: DW]);
    end
    next_cycle();
    for (int c = 5; c < 12; c++) begin
      int g;
      int h;
      g = (c - 5) % 4;
      h = (c - 4) % 4;
      bank_ret(2, 32'h100 + c);
      #2;
      n_checks++;
      if (usr_ready !== 5'(1 << g) || usr_dout_vld !== 5'(1 << h) || usr_dout[h*DW +: DW] !== 32'h100 + c) begin
        n_fail++; $display("FAIL rr_steady c=%0d: got ready=%b vld=%b dout=%h want ready=%b vld=%b dout=%h",
                           c, usr_ready, usr_dout_vld, usr_dout[h*DW +: DW], 5'(1 << g), 5'(1 << h), 32'h100 + c);
      end
      next_cycle();
    end
    clr_req();
    for (int c = 12; c < 15; c++) begin
      int h;
      h = (c - 4) % 4;
      bank_ret(2, 32'h100 + c);
      #2;
      n_checks++;
      if (usr_dout_vld !== 5'(1 << h) || usr_dout[h*DW +: DW] !== 32'h100 + c) begin
        n_fail++; $display("FAIL rr_drain c=%0d: got vld=%b dout=%h want vld=%b dout=%h",
                           c, usr_dout_vld, usr_dout[h*DW +: DW], 5'(1 << h), 32'h100 + c);
      end
      next_cycle();
    end
  endtask

  task automatic test_fifo_full();
    for (int p = 0; p < 4; p++) set_req(p, 1'b1, 1'b0, 2'd3, 32'h10 * p, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #2;
      n_checks++;
      if (usr_ready !== 5'(1 << c) || cyclic_mux_re !== 4'b0001) begin
        n_fail++; $display("FAIL full_fill c=%0d: got ready=%b re=%b want %b/0001", c, usr_ready, cyclic_mux_re, 5'(1 << c));
      end
      next_cycle();
    end
    clr_req();
    set_req(4, 1'b1, 1'b0, 2'd3, 32'h40, 32'h0);
    #2;
    n_checks++;
    if (usr_ready !== 5'b0 || cyclic_mux_re !== 4'b0) begin
      n_fail++; $display("FAIL full_block: got ready=%b re=%b want 0/0", usr_ready, cyclic_mux_re);
    end
    next_cycle();
    set_req(4, 1'b0, 1'b1, 2'd3, 32'h40, 32'h77);
    #2;
    n_checks++;
    if (usr_ready !== 5'b10000 || cyclic_mux_we !== 4'b0001) begin
      n_fail++; $display("FAIL full_write: got ready=%b we=%b want 10000/0001", usr_ready, cyclic_mux_we);
    end
    next_cycle();
    set_req(4, 1'b1, 1'b0, 2'd3, 32'h40, 32'h0);
    bank_ret(0, 32'h200);
    #2;
    n_checks++;
    if (usr_ready !== 5'b10000 || cyclic_mux_re !== 4'b0001 ||
        usr_dout_vld !== 5'b00001 || usr_dout[0 +: DW] !== 32'h200) begin
      n_fail++; $display("FAIL full_pop_accept: got ready=%b re=%b vld=%b dout=%h want 10000/0001/00001/200",
                         usr_ready, cyclic_mux_re, usr_dout_vld, usr_dout[0 +: DW]);
    end
    next_cycle();
    clr_req();
    for (int k = 1; k < 5; k++) begin
      bank_ret(0, 32'h200 + k);
      #2;
      n_checks++;
      if (usr_dout_vld !== 5'(1 << k) || usr_dout[k*DW +: DW] !== 32'h200 + k) begin
        n_fail++; $display("FAIL full_drain k=%0d: got vld=%b dout=%h want %b/%h",
                           k, usr_dout_vld, usr_dout[k*DW +: DW], 5'(1 << k), 32'h200 + k);
      end
      next_cycle();
    end
  endtask

  task automatic test_cross_bank();
    set_req(1, 1'b1, 1'b0, 2'd3, 32'h0C, 32'h0);
    set_req(2, 1'b1, 1'b0, 2'd3, 32'h00, 32'h0);
    #2;
    n_checks++;
    if (usr_ready !== 5'b00110 || cyclic_mux_re !== 4'b1001) begin
      n_fail++; $display("FAIL xbank_accept: got ready=%b re=%b want 00110/1001", usr_ready, cyclic_mux_re);
    end
    next_cycle();
    clr_req();
    bank_ret(0, 32'hB0B0);
    #2;
    n_checks++;
    if (usr_dout_vld !== 5'b00100 || usr_dout[2*DW +: DW] !== 32'hB0B0) begin
      n_fail++; $display("FAIL xbank_first: got vld=%b dout=%h want 00100/b0b0", usr_dout_vld, usr_dout[2*DW +: DW]);
    end
    next_cycle();
    bank_ret(3, 32'hC3C3);
    #2;
    n_checks++;
    if (usr_dout_vld !== 5'b00010 || usr_dout[1*DW +: DW] !== 32'hC3C3) begin
      n_fail++; $display("FAIL xbank_second: got vld=%b dout=%h want 00010/c3c3", usr_dout_vld, usr_dout[1*DW +: DW]);
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b1, 1'b0, 2'd3, 32'h04, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'd3, 32'h08, 32'h0);
    #2;
    n_checks++;
    if (usr_ready !== 5'b00011) begin n_fail++; $display("FAIL mid_accept: got %b want 00011", usr_ready); end
    next_cycle();
    clr_req();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    bank_ret(1, 32'hDEAD);
    #2;
    n_checks++;
    if (usr_dout_vld !== 5'b0 || err_orphan_rd !== 1'b0) begin
      n_fail++; $display("FAIL mid_drop: got vld=%b err=%b want 0/0", usr_dout_vld, err_orphan_rd);
    end
    next_cycle();
    n_checks++;
    if (usr_dout_vld !== 5'b0 || err_orphan_rd !== 1'b1) begin
      n_fail++; $display("FAIL mid_orphan: got vld=%b err=%b want 0/1", usr_dout_vld, err_orphan_rd);
    end
    set_req(0, 1'b1, 1'b0, 2'd3, 32'h04, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'd3, 32'h14, 32'h0);
    #2;
    n_checks++;
    if (usr_ready !== 5'b00001) begin
      n_fail++; $display("FAIL mid_rr_pend_cleared: got ready=%b want 00001", usr_ready);
    end
    next_cycle();
    clr_req();
    next_cycle();
    n_checks++;
    if (err_orphan_rd !== 1'b1) begin n_fail++; $display("FAIL mid_sticky: got %b want 1", err_orphan_rd); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    rstn                = 1'b0;
    usr_re              = '0;
    usr_we              = '0;
    usr_len             = '0;
    usr_adr             = '0;
    usr_din             = '0;
    cyclic_mux_ready    = '1;
    cyclic_mux_dout     = '0;
    cyclic_mux_dout_vld = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_steering();
    test_rdata_latency();
`ifndef CYCLIC_REQMUX_RDATA_REG_EN
    test_round_robin();
    test_fifo_full();
    test_cross_bank();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
